matrix_store_writer: RTL and testbench

//  Initiator side of the matrix manager alloc/commit protocol. Accepts one m x n matrix

---
 rtl/matrix_store_writer_pkg.sv | 36 +++
 rtl/matrix_store_writer_if.sv | 45 ++++
 rtl/matrix_store_writer_addr_gen.sv | 40 ++++
 rtl/matrix_store_writer.sv | 177 +++++++++++++++++
 tb/tb_matrix_store_writer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_store_writer_pkg.sv
// Shared constants, error codes, FSM encoding and dimension helpers for matrix_store_writer.
// Optional build macro MATRIX_WR_ZERO_FILL_EN is consumed by the top module.
package matrix_store_writer_pkg;

    localparam int ELEMENT_WIDTH = 16;
    localparam int MAX_DIM    = 5;
    localparam int ADDR_WIDTH = 12;
    localparam int DIM_WIDTH  = 5;
    localparam int SLOT_WIDTH = 4;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_DIM  = 2'd1;
    localparam logic [1:0] ERR_NO_SPACE = 2'd2;
    localparam logic [1:0] ERR_ABORTED  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FILL   = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    // A dimension is legal when it is in 1..MAX_DIM.
    function automatic logic dim_ok(input logic [DIM_WIDTH-1:0] d);
        return (d != '0) && (d <= DIM_WIDTH'(MAX_DIM));
    endfunction

    // Number of elements in an m x n matrix, sized to the element address.
    function automatic logic [ADDR_WIDTH-1:0] elem_total(input logic [DIM_WIDTH-1:0] m,
                                                         input logic [DIM_WIDTH-1:0] n);
        return ADDR_WIDTH'(m) * ADDR_WIDTH'(n);
    endfunction

endpackage

// File: rtl/matrix_store_writer_if.sv
// Element stream plus manager alloc/commit signals of matrix_store_writer.
// Handshake: an element transfers on a rising clk edge where elem_valid and
// elem_ready are both high; the source holds elem_data/elem_last stable while
// elem_valid is high and not yet accepted. alloc_req and commit_req are single
// cycle pulses; alloc_valid answers in the cycle after alloc_req.
interface matrix_store_writer_if;
    import matrix_store_writer_pkg::*;

    logic                     elem_valid;
    logic [ELEMENT_WIDTH-1:0] elem_data;
    logic                     elem_last;
    logic                     elem_ready;

    logic                     alloc_req;
    logic [DIM_WIDTH-1:0]     alloc_m;
    logic [DIM_WIDTH-1:0]     alloc_n;
    logic                     alloc_valid;
    logic [SLOT_WIDTH-1:0]    alloc_slot;
    logic [ADDR_WIDTH-1:0]    alloc_addr;

    logic                     commit_req;
    logic [SLOT_WIDTH-1:0]    commit_slot;
    logic [DIM_WIDTH-1:0]     commit_m;
    logic [DIM_WIDTH-1:0]     commit_n;
    logic [ADDR_WIDTH-1:0]    commit_addr;

    // Writer side (initiator of alloc/commit, sink of the element stream).
    modport master (
        input  elem_valid, elem_data, elem_last,
        output elem_ready,
        output alloc_req, alloc_m, alloc_n,
        input  alloc_valid, alloc_slot, alloc_addr,
        output commit_req, commit_slot, commit_m, commit_n, commit_addr
    );

    // Front-end / manager side.
    modport slave (
        output elem_valid, elem_data, elem_last,
        input  elem_ready,
        input  alloc_req, alloc_m, alloc_n,
        output alloc_valid, alloc_slot, alloc_addr,
        input  commit_req, commit_slot, commit_m, commit_n, commit_addr
    );

endinterface

// File: rtl/matrix_store_writer_addr_gen.sv
// Element counter and BRAM address generator: holds the granted base, counts
// written elements and flags the final / past-final element against m*n.
module matrix_store_writer_addr_gen
    import matrix_store_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base_in,
    input  logic [ADDR_WIDTH-1:0] total,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] base,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  is_last,
    output logic                  at_end
);

    logic [ADDR_WIDTH-1:0] cnt;

    // Load the base and clear the count on a grant, count each written element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            cnt  <= '0;
        end else if (load) begin
            base <= base_in;
            cnt  <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Current write address and position of the count relative to m*n.
    always_comb begin
        addr    = base + cnt;
        is_last = (cnt + 1'b1) == total;
        at_end  = cnt == total;
    end

endmodule

// File: rtl/matrix_store_writer.sv
// Initiator of the matrix manager alloc/commit protocol: requests a slot, streams
// row-major elements into data BRAM, then commits the directory entry.
// Build option: MATRIX_WR_ZERO_FILL_EN pads a short stream with zeros instead of failing.
module matrix_store_writer
    import matrix_store_writer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DIM_WIDTH-1:0]     req_m,
    input  logic [DIM_WIDTH-1:0]     req_n,
    input  logic                     abort,
    matrix_store_writer_if.master    bus,
    output logic                     bram_we,
    output logic [ADDR_WIDTH-1:0]    bram_addr,
    output logic [ELEMENT_WIDTH-1:0] bram_din,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output state_t                   fsm_state
);

    state_t                state, state_nx;
    logic [DIM_WIDTH-1:0]  m_q, n_q;
    logic [SLOT_WIDTH-1:0] slot_q;
    logic [ADDR_WIDTH-1:0] total, base, wr_addr;
    logic                  is_last, at_end, hs;
    logic                  latch_req, load, wr_en, wr_zero;
    logic                  err_set, code_we;
    logic [1:0]            code_val;

    matrix_store_writer_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .base_in (bus.alloc_addr),
        .total   (total),
        .inc     (wr_en),
        .base    (base),
        .addr    (wr_addr),
        .is_last (is_last),
        .at_end  (at_end)
    );

    // Moore outputs and the element handshake.
    always_comb begin
        total           = elem_total(m_q, n_q);
        bus.elem_ready  = (state == ST_WRITE) && !at_end;
        hs              = bus.elem_valid && bus.elem_ready;
        bus.alloc_req   = state == ST_REQ;
        bus.alloc_m     = m_q;
        bus.alloc_n     = n_q;
        bus.commit_req  = state == ST_COMMIT;
        bus.commit_slot = slot_q;
        bus.commit_m    = m_q;
        bus.commit_n    = n_q;
        bus.commit_addr = base;
        done            = state == ST_COMMIT;
        busy            = state != ST_IDLE;
        fsm_state       = state;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state and per-cycle control strobes; abort takes priority over a handshake.
    always_comb begin
        state_nx  = state;
        latch_req = 1'b0;
        load      = 1'b0;
        wr_en     = 1'b0;
        wr_zero   = 1'b0;
        err_set   = 1'b0;
        code_we   = 1'b0;
        code_val  = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    code_we = 1'b1;
                    if (dim_ok(req_m) && dim_ok(req_n)) begin
                        latch_req = 1'b1;
                        state_nx  = ST_REQ;
                    end else begin
                        err_set  = 1'b1;
                        code_val = ERR_BAD_DIM;
                    end
                end
            end
            ST_REQ: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.alloc_valid) begin
                    load     = 1'b1;
                    state_nx = ST_WRITE;
                end else begin
                    err_set  = 1'b1;
                    code_we  = 1'b1;
                    code_val = ERR_NO_SPACE;
                    state_nx = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (at_end) begin
                    state_nx = ST_COMMIT;
                end else if (hs) begin
                    wr_en = 1'b1;
                    if (bus.elem_last && !is_last) begin
`ifdef MATRIX_WR_ZERO_FILL_EN
                        state_nx = ST_FILL;
`else
                        err_set  = 1'b1;
                        code_we  = 1'b1;
                        code_val = ERR_ABORTED;
                        state_nx = ST_IDLE;
`endif
                    end
                end
            end
            ST_FILL: begin
                if (at_end) begin
                    state_nx = ST_COMMIT;
                end else begin
                    wr_en   = 1'b1;
                    wr_zero = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (abort && (state == ST_REQ || state == ST_WAIT ||
                      state == ST_WRITE || state == ST_FILL)) begin
            state_nx = ST_IDLE;
            load     = 1'b0;
            wr_en    = 1'b0;
            err_set  = 1'b1;
            code_we  = 1'b1;
            code_val = ERR_ABORTED;
        end
    end

    // Request and grant latches, registered BRAM port and error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            n_q       <= '0;
            slot_q    <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            if (latch_req) begin
                m_q <= req_m;
                n_q <= req_n;
            end
            if (load) slot_q <= bus.alloc_slot;
            bram_we <= wr_en;
            if (wr_en) begin
                bram_addr <= wr_addr;
                bram_din  <= wr_zero ? '0 : bus.elem_data;
            end
            err <= err_set;
            if (code_we) err_code <= code_val;
        end
    end

endmodule

// File: tb/tb_matrix_store_writer.sv
// Self-checking bench for matrix_store_writer: a manager responder grants slots,
// a negedge monitor checks BRAM writes, alloc dims and commits against expected queues.
module tb_matrix_store_writer;
    import matrix_store_writer_pkg::*;

    localparam int WW = ADDR_WIDTH + ELEMENT_WIDTH;
    localparam int CW = SLOT_WIDTH + 2 * DIM_WIDTH + ADDR_WIDTH;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic [DIM_WIDTH-1:0]     req_m = '0;
    logic [DIM_WIDTH-1:0]     req_n = '0;
    logic                     bram_we;
    logic [ADDR_WIDTH-1:0]    bram_addr;
    logic [ELEMENT_WIDTH-1:0] bram_din;
    logic                     busy, done, err;
    logic [1:0]               err_code;
    state_t                   fsm_state;
    logic                     mgr_grant = 1'b1;

    matrix_store_writer_if bus ();

    matrix_store_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req_m     (req_m),
        .req_n     (req_n),
        .abort     (abort),
        .bus       (bus.master),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    logic [WW-1:0]          exp_q[$];
    logic [CW-1:0]          exp_commit_q[$];
    logic [2*DIM_WIDTH-1:0] exp_alloc_q[$];

    int n_cmp = 0, n_mis = 0;
    int wr_cnt = 0, commit_cnt = 0, done_cnt = 0, err_cnt = 0, alloc_cnt = 0;
    int w0, c0, d0, e0, a0;
    logic prev_we = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Manager model: answers alloc_req in the following cycle.
    initial begin
        logic seen;
        bus.alloc_valid = 1'b0;
        forever begin
            @(negedge clk);
            seen = bus.alloc_req;
            @(posedge clk);
            #1;
            bus.alloc_valid = seen && mgr_grant;
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bram_we) begin
                    wr_cnt++;
                    if (exp_q.size() != 0) check("bram_write", 64'({bram_addr, bram_din}), 64'(exp_q.pop_front()));
                end
                if (bus.commit_req) begin
                    commit_cnt++;
                    check("commit_after_we", 64'(prev_we), 64'(1));
                    check("done_with_commit", 64'(done), 64'(1));
                    if (exp_commit_q.size() != 0)
                        check("commit_fields", 64'({bus.commit_slot, bus.commit_m, bus.commit_n, bus.commit_addr}),
                              64'(exp_commit_q.pop_front()));
                end
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (bus.alloc_req) begin
                    alloc_cnt++;
                    if (exp_alloc_q.size() != 0) check("alloc_dims", 64'({bus.alloc_m, bus.alloc_n}), 64'(exp_alloc_q.pop_front()));
                end
                prev_we = bram_we;
            end
        end
    end

    task automatic snap();
        w0 = wr_cnt; c0 = commit_cnt; d0 = done_cnt; e0 = err_cnt; a0 = alloc_cnt;
    endtask

    task automatic do_start(input int m, input int n);
        @(posedge clk); #1;
        start = 1'b1; req_m = DIM_WIDTH'(m); req_n = DIM_WIDTH'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_elem(input logic [ELEMENT_WIDTH-1:0] d, input logic last, input logic [ADDR_WIDTH-1:0] addr);
        int waited;
        bit ok;
        waited = 0; ok = 1'b0;
        bus.elem_valid = 1'b1; bus.elem_data = d; bus.elem_last = last;
        while (!ok && waited < 60) begin
            @(negedge clk);
            if (bus.elem_ready) begin
                exp_q.push_back({addr, d});
                ok = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        bus.elem_valid = 1'b0; bus.elem_last = 1'b0;
        if (!ok) check("elem_ready_timeout", 64'(waited), 64'(0));
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_mgr(input bit grant, input int slot, input int addr);
        mgr_grant = grant;
        bus.alloc_slot = SLOT_WIDTH'(slot);
        bus.alloc_addr = ADDR_WIDTH'(addr);
    endtask

    initial begin
        logic [ELEMENT_WIDTH-1:0] d;
        int base;
        bus.elem_valid = 1'b0; bus.elem_data = '0; bus.elem_last = 1'b0;
        bus.alloc_slot = '0; bus.alloc_addr = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_bram_we", 64'(bram_we), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_err_code", 64'(err_code), 64'(ERR_NONE));
        check("rst_alloc_req", 64'(bus.alloc_req), 64'(0));
        check("rst_commit_req", 64'(bus.commit_req), 64'(0));
        check("rst_elem_ready", 64'(bus.elem_ready), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic 2x3 transfer, plus an extra element offered after the last one.
        snap();
        set_mgr(1'b1, 3, 'h010);
        exp_alloc_q.push_back({5'd2, 5'd3});
        exp_commit_q.push_back({4'd3, 5'd2, 5'd3, 12'h010});
        do_start(2, 3);
        for (int i = 0; i < 6; i++)
            send_elem(ELEMENT_WIDTH'(i + 1), i == 5, ADDR_WIDTH'('h010 + i));
        bus.elem_valid = 1'b1; bus.elem_data = ELEMENT_WIDTH'(7);
        repeat (4) @(posedge clk);
        #1 bus.elem_valid = 1'b0;
        wait_idle();
        check("basic_writes", 64'(wr_cnt - w0), 64'(6));
        check("basic_commits", 64'(commit_cnt - c0), 64'(1));
        check("basic_done", 64'(done_cnt - d0), 64'(1));
        check("basic_err", 64'(err_cnt - e0), 64'(0));
        check("basic_err_code", 64'(err_code), 64'(ERR_NONE));

        // Illegal dimensions.
        snap();
        do_start(0, 3);
        wait_idle();
        check("dim0_err", 64'(err_cnt - e0), 64'(1));
        check("dim0_code", 64'(err_code), 64'(ERR_BAD_DIM));
        check("dim0_alloc", 64'(alloc_cnt - a0), 64'(0));
        snap();
        do_start(3, 6);
        wait_idle();
        check("dim6_err", 64'(err_cnt - e0), 64'(1));
        check("dim6_code", 64'(err_code), 64'(ERR_BAD_DIM));
        check("dim6_alloc", 64'(alloc_cnt - a0), 64'(0));

        // No space at the manager.
        snap();
        set_mgr(1'b0, 1, 'h040);
        exp_alloc_q.push_back({5'd2, 5'd2});
        do_start(2, 2);
        wait_idle();
        check("nospace_code", 64'(err_code), 64'(ERR_NO_SPACE));
        check("nospace_err", 64'(err_cnt - e0), 64'(1));
        check("nospace_writes", 64'(wr_cnt - w0), 64'(0));
        check("nospace_commits", 64'(commit_cnt - c0), 64'(0));
        check("nospace_alloc", 64'(alloc_cnt - a0), 64'(1));

        // Abort after two of four elements.
        snap();
        set_mgr(1'b1, 5, 'h080);
        exp_alloc_q.push_back({5'd2, 5'd2});
        do_start(2, 2);
        send_elem(ELEMENT_WIDTH'('h11), 1'b0, ADDR_WIDTH'('h080));
        send_elem(ELEMENT_WIDTH'('h22), 1'b0, ADDR_WIDTH'('h081));
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_idle();
        check("abort_code", 64'(err_code), 64'(ERR_ABORTED));
        check("abort_writes", 64'(wr_cnt - w0), 64'(2));
        check("abort_commits", 64'(commit_cnt - c0), 64'(0));

        // Abort coinciding with a handshake drops the element.
        snap();
        exp_alloc_q.push_back({5'd2, 5'd2});
        do_start(2, 2);
        for (int i = 0; i < 20 && !bus.elem_ready; i++) @(negedge clk);
        check("abort_hs_ready", 64'(bus.elem_ready), 64'(1));
        bus.elem_valid = 1'b1; bus.elem_data = ELEMENT_WIDTH'('h55); abort = 1'b1;
        @(posedge clk); #1;
        bus.elem_valid = 1'b0; abort = 1'b0;
        wait_idle();
        check("abort_hs_writes", 64'(wr_cnt - w0), 64'(0));
        check("abort_hs_code", 64'(err_code), 64'(ERR_ABORTED));

        // Short stream: elem_last on the second of four elements.
        snap();
        set_mgr(1'b1, 6, 'h100);
        exp_alloc_q.push_back({5'd2, 5'd2});
`ifdef MATRIX_WR_ZERO_FILL_EN
        exp_commit_q.push_back({4'd6, 5'd2, 5'd2, 12'h100});
`endif
        do_start(2, 2);
        send_elem(ELEMENT_WIDTH'('hA1), 1'b0, ADDR_WIDTH'('h100));
        send_elem(ELEMENT_WIDTH'('hA2), 1'b1, ADDR_WIDTH'('h101));
`ifdef MATRIX_WR_ZERO_FILL_EN
        exp_q.push_back({12'h102, ELEMENT_WIDTH'(0)});
        exp_q.push_back({12'h103, ELEMENT_WIDTH'(0)});
        wait_idle();
        check("short_writes", 64'(wr_cnt - w0), 64'(4));
        check("short_commits", 64'(commit_cnt - c0), 64'(1));
        check("short_err", 64'(err_cnt - e0), 64'(0));
`else
        wait_idle();
        check("short_writes", 64'(wr_cnt - w0), 64'(2));
        check("short_commits", 64'(commit_cnt - c0), 64'(0));
        check("short_code", 64'(err_code), 64'(ERR_ABORTED));
`endif

        // 5x5 with valid toggling, plus a start while busy that must be ignored.
        snap();
        base = 'h200;
        set_mgr(1'b1, 9, base);
        exp_alloc_q.push_back({5'd5, 5'd5});
        exp_commit_q.push_back({4'd9, 5'd5, 5'd5, 12'h200});
        do_start(5, 5);
        for (int i = 0; i < 25; i++) begin
            d = ELEMENT_WIDTH'($urandom_range(0, 65535));
            send_elem(d, i == 24, ADDR_WIDTH'(base + i));
            if (i == 10) begin
                start = 1'b1; req_m = 5'd1; req_n = 5'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_idle();
        check("big_writes", 64'(wr_cnt - w0), 64'(25));
        check("big_commits", 64'(commit_cnt - c0), 64'(1));
        check("big_alloc", 64'(alloc_cnt - a0), 64'(1));
        check("big_err", 64'(err_cnt - e0), 64'(0));
        check("big_code", 64'(err_code), 64'(ERR_NONE));

        // Reset in the middle of a transfer.
        snap();
        exp_alloc_q.push_back({5'd2, 5'd2});
        do_start(2, 2);
        send_elem(ELEMENT_WIDTH'('h33), 1'b0, ADDR_WIDTH'('h200));
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_code", 64'(err_code), 64'(ERR_NONE));
        check("midrst_we", 64'(bram_we), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_commits", 64'(commit_cnt - c0), 64'(0));
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        check("commit_q_drained", 64'(exp_commit_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
